// File: rtl/write_back_multi.sv
// -----------------------------------------------------------------------------
// write_back_multi
//
// Multi-lane commit stage. Accepts one bundle of LANES results per handshake,
// holds it, and drains the register-file writes through WPORTS write ports.
// Each drain cycle uses the lowest pending lanes first. When the last drain
// cycle is reached, the bundle retires and the architectural HI/LO registers
// are updated together.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid / in_ready    bundle handshake (transfer when both are high at an edge)
//   in_wen, in_regw,       per-lane register-file write request, destination
//   in_data                and data; lane i is at [i*W +: W]
//   in_hi_w, in_lo_w,      per-lane HI/LO write requests and data
//   in_hi_data, in_lo_data
//   rf_we, rf_wa, rf_wd    register-file write ports (combinational from the
//                          holding register)
//   hi_o, lo_o             architectural HI/LO (registered)
//   retire                 one-cycle pulse in the cycle a bundle fully commits
//   busy                   holding register occupied
// -----------------------------------------------------------------------------
module write_back_multi #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int AW     = 5,
  parameter int DW     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES-1:0]    in_wen,
  input  logic [LANES*AW-1:0] in_regw,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [LANES-1:0]    in_hi_w,
  input  logic [LANES-1:0]    in_lo_w,
  input  logic [LANES*DW-1:0] in_hi_data,
  input  logic [LANES*DW-1:0] in_lo_data,
  output logic [WPORTS-1:0]   rf_we,
  output logic [WPORTS*AW-1:0] rf_wa,
  output logic [WPORTS*DW-1:0] rf_wd,
  output logic [DW-1:0]       hi_o,
  output logic [DW-1:0]       lo_o,
  output logic                retire,
  output logic                busy
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, state_nxt;

  // Holding register and the mask of lanes that still owe a write.
  logic [LANES-1:0]    pending, pending_nxt;
  logic [LANES*AW-1:0] h_regw;
  logic [LANES*DW-1:0] h_data;
  logic [LANES-1:0]    h_hi_w, h_lo_w;
  logic [LANES*DW-1:0] h_hi_data, h_lo_data;

  logic [LANES-1:0] cap_pending;  // pending mask for the bundle on the inputs
  logic [LANES-1:0] grant;        // lanes issued on a port this cycle
  logic             last;         // this drain cycle empties the holding register
  logic             accept;
  logic [DW-1:0]    hi_nxt, lo_nxt;

  assign accept = in_valid & in_ready;

  // WAW collapse at capture: a lane writes only if no higher lane targets the
  // same register. r0 is never written. A higher lane with the same nonzero
  // destination is necessarily a valid write, so the r0 test is needed once.
  always_comb begin
    cap_pending = '0;
    for (int i = 0; i < LANES; i++) begin
      cap_pending[i] = in_wen[i] && (in_regw[i*AW +: AW] != '0);
      for (int j = i + 1; j < LANES; j++) begin
        if (in_wen[j] && (in_regw[j*AW +: AW] == in_regw[i*AW +: AW]))
          cap_pending[i] = 1'b0;
      end
    end
  end

  // Last drain cycle: everything left fits on the ports. This also covers an
  // empty bundle, which still spends exactly one DRAIN cycle.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < LANES; i++) begin
      if (pending[i]) cnt++;
    end
    last = (cnt <= WPORTS);
  end

  // HI/LO commit value: the highest lane with a set request wins.
  always_comb begin
    hi_nxt = hi_o;
    lo_nxt = lo_o;
    for (int i = 0; i < LANES; i++) begin
      if (h_hi_w[i]) hi_nxt = h_hi_data[i*DW +: DW];
      if (h_lo_w[i]) lo_nxt = h_lo_data[i*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      pending <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (retire) begin
        hi_o <= hi_nxt;
        lo_o <= lo_nxt;
      end
    end
  end

  // NOTE: the holding data is not reset; it is only observed through pending
  // bits and the DRAIN state, both of which are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_regw    <= in_regw;
      h_data    <= in_data;
      h_hi_w    <= in_hi_w;
      h_lo_w    <= in_lo_w;
      h_hi_data <= in_hi_data;
      h_lo_data <= in_lo_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no latch is
  // inferred on any path.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = DRAIN;
      DRAIN:   if (last)     state_nxt = in_valid ? DRAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
    // A new bundle replaces whatever was left; otherwise issued lanes retire.
    if (accept)
      pending_nxt = cap_pending;
    else if (state == DRAIN)
      pending_nxt = pending & ~grant;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // A pending lane's rank is the number of pending lanes below it; ranks
  // 0..WPORTS-1 map directly onto ports in ascending lane order.
  always_comb begin
    int rank;
    rank     = 0;
    grant    = '0;
    rf_we    = '0;
    rf_wa    = '0;
    rf_wd    = '0;
    busy     = (state == DRAIN);
    retire   = (state == DRAIN) && last;
    in_ready = (state == IDLE) || ((state == DRAIN) && last);
    for (int i = 0; i < LANES; i++) begin
      if ((state == DRAIN) && pending[i]) begin
        for (int p = 0; p < WPORTS; p++) begin
          if (p == rank) begin
            grant[i]            = 1'b1;
            rf_we[p]            = 1'b1;
            rf_wa[p*AW +: AW]   = h_regw[i*AW +: AW];
            rf_wd[p*DW +: DW]   = h_data[i*DW +: DW];
          end
        end
        rank++;
      end
    end
  end

endmodule

// File: tb/tb_write_back_multi.sv
// -----------------------------------------------------------------------------
// tb_write_back_multi
//
// Three instances of write_back_multi (2 lanes/1 port, 4 lanes/2 ports,
// 2 lanes/2 ports); one is active at a time. A transaction-level model turns
// each accepted bundle into the sequence of per-cycle port frames it should
// produce, and every cycle the active DUT is compared with the head frame.
// -----------------------------------------------------------------------------
module tb_write_back_multi;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [3:0]         wen;
    logic [3:0]         hi_w;
    logic [3:0]         lo_w;
    logic [3:0][AW-1:0] regw;
    logic [3:0][DW-1:0] data;
    logic [3:0][DW-1:0] hi_d;
    logic [3:0][DW-1:0] lo_d;
  } bundle_t;

  typedef struct packed {
    logic [1:0]         we;
    logic [1:0][AW-1:0] wa;
    logic [1:0][DW-1:0] wd;
    logic               retire;
    logic               hs;
    logic               ls;
    logic [DW-1:0]      hv;
    logic [DW-1:0]      lv;
  } frame_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Shared stimulus (4-lane wide); 2-lane instances see the low lanes.
  logic [2:0]      in_valid_v;
  logic [3:0]      in_wen, in_hi_w, in_lo_w;
  logic [4*AW-1:0] in_regw;
  logic [4*DW-1:0] in_data, in_hi_data, in_lo_data;

  logic [0:0]      we_a;  logic [AW-1:0]   wa_a;  logic [DW-1:0]   wd_a;
  logic [1:0]      we_b;  logic [2*AW-1:0] wa_b;  logic [2*DW-1:0] wd_b;
  logic [1:0]      we_c;  logic [2*AW-1:0] wa_c;  logic [2*DW-1:0] wd_c;
  logic [DW-1:0]   hi_a, lo_a, hi_b, lo_b, hi_c, lo_c;
  logic [2:0]      rdy, ret, bsy;

  write_back_multi #(.LANES(2), .WPORTS(1), .AW(AW), .DW(DW)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_v[0]), .in_ready(rdy[0]),
    .in_wen(in_wen[1:0]), .in_regw(in_regw[2*AW-1:0]), .in_data(in_data[2*DW-1:0]),
    .in_hi_w(in_hi_w[1:0]), .in_lo_w(in_lo_w[1:0]),
    .in_hi_data(in_hi_data[2*DW-1:0]), .in_lo_data(in_lo_data[2*DW-1:0]),
    .rf_we(we_a), .rf_wa(wa_a), .rf_wd(wd_a), .hi_o(hi_a), .lo_o(lo_a),
    .retire(ret[0]), .busy(bsy[0]));

  write_back_multi #(.LANES(4), .WPORTS(2), .AW(AW), .DW(DW)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_v[1]), .in_ready(rdy[1]),
    .in_wen(in_wen), .in_regw(in_regw), .in_data(in_data),
    .in_hi_w(in_hi_w), .in_lo_w(in_lo_w),
    .in_hi_data(in_hi_data), .in_lo_data(in_lo_data),
    .rf_we(we_b), .rf_wa(wa_b), .rf_wd(wd_b), .hi_o(hi_b), .lo_o(lo_b),
    .retire(ret[1]), .busy(bsy[1]));

  write_back_multi #(.LANES(2), .WPORTS(2), .AW(AW), .DW(DW)) u_c (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_v[2]), .in_ready(rdy[2]),
    .in_wen(in_wen[1:0]), .in_regw(in_regw[2*AW-1:0]), .in_data(in_data[2*DW-1:0]),
    .in_hi_w(in_hi_w[1:0]), .in_lo_w(in_lo_w[1:0]),
    .in_hi_data(in_hi_data[2*DW-1:0]), .in_lo_data(in_lo_data[2*DW-1:0]),
    .rf_we(we_c), .rf_wa(wa_c), .rf_wd(wd_c), .hi_o(hi_c), .lo_o(lo_c),
    .retire(ret[2]), .busy(bsy[2]));

  // Observed view of the active instance, padded to two ports.
  int              sel;
  logic [1:0]      o_we;
  logic [2*AW-1:0] o_wa;
  logic [2*DW-1:0] o_wd;
  logic [DW-1:0]   o_hi, o_lo;
  logic            o_rdy, o_ret, o_bsy;

  always_comb begin
    o_we = '0; o_wa = '0; o_wd = '0;
    o_hi = '0; o_lo = '0; o_rdy = 1'b0; o_ret = 1'b0; o_bsy = 1'b0;
    case (sel)
      0: begin
        o_we = {1'b0, we_a}; o_wa = {{AW{1'b0}}, wa_a}; o_wd = {{DW{1'b0}}, wd_a};
        o_hi = hi_a; o_lo = lo_a; o_rdy = rdy[0]; o_ret = ret[0]; o_bsy = bsy[0];
      end
      1: begin
        o_we = we_b; o_wa = wa_b; o_wd = wd_b;
        o_hi = hi_b; o_lo = lo_b; o_rdy = rdy[1]; o_ret = ret[1]; o_bsy = bsy[1];
      end
      default: begin
        o_we = we_c; o_wa = wa_c; o_wd = wd_c;
        o_hi = hi_c; o_lo = lo_c; o_rdy = rdy[2]; o_ret = ret[2]; o_bsy = bsy[2];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s sel=%0d t=%0t got=0x%0h expected=0x%0h", tag, sel, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each accepted bundle becomes a list of expected frames.
  // ---------------------------------------------------------------------------
  int      nl, np;          // lanes and ports of the active instance
  frame_t  exp_q[$];
  logic [DW-1:0] exp_hi, exp_lo;
  bundle_t stim[$];
  bundle_t cur;
  bit      drv_valid;
  bit      ready_s;
  int      gap_pct;

  task automatic push_frames(input bundle_t b);
    int     winner[32];
    int     lq[$];
    int     k, ncyc, idx;
    frame_t f;
    logic          hs, ls;
    logic [DW-1:0] hv, lv;
    // Last writer to each register wins; r0 is never written.
    for (int a = 0; a < 32; a++) winner[a] = -1;
    for (int i = 0; i < nl; i++)
      if (b.wen[i] && b.regw[i] != 0) winner[b.regw[i]] = i;
    for (int i = 0; i < nl; i++)
      if (b.wen[i] && b.regw[i] != 0 && winner[b.regw[i]] == i) lq.push_back(i);
    hs = 1'b0; ls = 1'b0; hv = '0; lv = '0;
    for (int i = 0; i < nl; i++) begin
      if (b.hi_w[i]) begin hs = 1'b1; hv = b.hi_d[i]; end
      if (b.lo_w[i]) begin ls = 1'b1; lv = b.lo_d[i]; end
    end
    k    = lq.size();
    ncyc = (k == 0) ? 1 : (k + np - 1) / np;
    for (int c = 0; c < ncyc; c++) begin
      f = '0;
      for (int p = 0; p < np; p++) begin
        idx = c * np + p;
        if (idx < k) begin
          f.we[p] = 1'b1;
          f.wa[p] = b.regw[lq[idx]];
          f.wd[p] = b.data[lq[idx]];
        end
      end
      if (c == ncyc - 1) begin
        f.retire = 1'b1; f.hs = hs; f.ls = ls; f.hv = hv; f.lv = lv;
      end
      exp_q.push_back(f);
    end
  endtask

  task automatic check_cycle();
    frame_t f;
    f = (exp_q.size() > 0) ? exp_q[0] : '0;
    ready_s = (exp_q.size() <= 1);
    check("rf_we",    64'(o_we),  64'(f.we));
    check("rf_wa",    64'(o_wa),  64'(f.wa));
    check("rf_wd",    o_wd,       f.wd);
    check("retire",   64'(o_ret), 64'(f.retire));
    check("busy",     64'(o_bsy), 64'(exp_q.size() > 0));
    check("in_ready", 64'(o_rdy), 64'(ready_s));
    check("hi_o",     64'(o_hi),  64'(exp_hi));
    check("lo_o",     64'(o_lo),  64'(exp_lo));
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = '0;
    for (int i = 0; i < nl; i++) begin
      b.wen[i]  = ($urandom_range(0, 3) != 0);
      b.regw[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
      b.data[i] = $urandom;
      b.hi_w[i] = ($urandom_range(0, 3) == 0);
      b.lo_w[i] = ($urandom_range(0, 3) == 0);
      b.hi_d[i] = $urandom;
      b.lo_d[i] = $urandom;
    end
    return b;
  endfunction

  // One clock: check at the falling edge, drive, then advance the model at
  // the rising edge. An undelivered bundle stays on the inputs unchanged.
  task automatic step();
    frame_t f;
    @(negedge clk);
    check_cycle();
    if (!drv_valid && stim.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      cur       = stim.pop_front();
      drv_valid = 1'b1;
    end
    if (drv_valid) begin
      in_wen = cur.wen; in_regw = cur.regw; in_data = cur.data;
      in_hi_w = cur.hi_w; in_lo_w = cur.lo_w; in_hi_data = cur.hi_d; in_lo_data = cur.lo_d;
    end else begin
      in_wen = 4'($urandom); in_regw = {$urandom, $urandom}; in_data = {4{$urandom}};
      in_hi_w = 4'($urandom); in_lo_w = 4'($urandom);
      in_hi_data = {4{$urandom}}; in_lo_data = {4{$urandom}};
    end
    in_valid_v      = '0;
    in_valid_v[sel] = drv_valid;
    @(posedge clk);
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      if (f.retire) begin
        if (f.hs) exp_hi = f.hv;
        if (f.ls) exp_lo = f.lv;
      end
    end
    if (drv_valid && ready_s) begin
      push_frames(cur);
      drv_valid = 1'b0;
    end
  endtask

  task automatic run_stim();
    int cycles;
    cycles = 0;
    while ((stim.size() > 0 || drv_valid || exp_q.size() > 0) && cycles < 5000) begin
      step();
      cycles++;
    end
    check("drain_timeout", 64'(cycles >= 5000), 64'd0);
    step();
  endtask

  // Call just after a falling edge; reset is released before the next rise.
  task automatic pulse_reset();
    resetn = 1'b0;
    in_valid_v = '0;
    #1;
    exp_q.delete();
    drv_valid = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("rst_rf_we",    64'(o_we),  64'd0);
    check("rst_retire",   64'(o_ret), 64'd0);
    check("rst_busy",     64'(o_bsy), 64'd0);
    check("rst_in_ready", 64'(o_rdy), 64'd1);
    check("rst_hi",       64'(o_hi),  64'd0);
    check("rst_lo",       64'(o_lo),  64'd0);
    #2;
    resetn = 1'b1;
  endtask

  task automatic select(input int s, input int lanes, input int ports);
    @(negedge clk);
    sel = s; nl = lanes; np = ports;
    pulse_reset();
  endtask

  bundle_t b;

  initial begin
    resetn = 1'b0;
    in_valid_v = '0;
    in_wen = '0; in_regw = '0; in_data = '0;
    in_hi_w = '0; in_lo_w = '0; in_hi_data = '0; in_lo_data = '0;
    drv_valid = 1'b0; ready_s = 1'b1; gap_pct = 0;
    exp_hi = '0; exp_lo = '0;
    sel = 0; nl = 2; np = 1;

    // ---------------- 2 lanes, 1 port ----------------
    select(0, 2, 1);

    // Two distinct writes drain over two cycles.
    b = '0; b.wen = 4'b0011;
    b.regw[0] = 5'd3; b.data[0] = 32'h11;
    b.regw[1] = 5'd4; b.data[1] = 32'h22;
    stim.push_back(b); run_stim();

    // Same destination in both lanes collapses to one write of the higher lane.
    b = '0; b.wen = 4'b0011;
    b.regw[0] = 5'd5; b.data[0] = 32'hAA;
    b.regw[1] = 5'd5; b.data[1] = 32'hBB;
    stim.push_back(b); run_stim();

    // r0 write suppressed; HI/LO still commit.
    b = '0; b.wen = 4'b0001;
    b.regw[0] = 5'd0; b.data[0] = 32'h55;
    b.hi_w = 4'b0001; b.hi_d[0] = 32'h1;
    b.lo_w = 4'b0010; b.lo_d[1] = 32'h2;
    stim.push_back(b); run_stim();
    check("hi_after_r0", 64'(o_hi), 64'h1);
    check("lo_after_r0", 64'(o_lo), 64'h2);

    // Both lanes write HI: highest lane wins, LO unchanged.
    b = '0; b.hi_w = 4'b0011; b.hi_d[0] = 32'h7; b.hi_d[1] = 32'h9;
    stim.push_back(b); run_stim();
    check("hi_two_lanes", 64'(o_hi), 64'h9);
    check("lo_kept",      64'(o_lo), 64'h2);

    // Three back-to-back two-write bundles with in_valid held.
    gap_pct = 0;
    for (int n = 0; n < 3; n++) begin
      b = '0; b.wen = 4'b0011;
      b.regw[0] = 5'(6 + 2*n); b.data[0] = 32'h100 + n;
      b.regw[1] = 5'(7 + 2*n); b.data[1] = 32'h200 + n;
      stim.push_back(b);
    end
    run_stim();

    // Reset in the first drain cycle of a two-write bundle.
    b = '0; b.wen = 4'b0011;
    b.regw[0] = 5'd10; b.data[0] = 32'hC0;
    b.regw[1] = 5'd11; b.data[1] = 32'hC1;
    b.hi_w = 4'b0001; b.hi_d[0] = 32'hDEAD;
    stim.push_back(b);
    step();
    @(negedge clk);
    check_cycle();
    pulse_reset();
    for (int n = 0; n < 3; n++) step();

    // Random traffic with idle gaps and held-off bundles.
    gap_pct = 30;
    for (int n = 0; n < 150; n++) stim.push_back(rand_bundle());
    run_stim();

    // ---------------- 4 lanes, 2 ports ----------------
    select(1, 4, 2);
    gap_pct = 0;
    b = '0; b.wen = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      b.regw[i] = 5'(12 + i); b.data[i] = 32'hA0 + i;
    end
    stim.push_back(b); run_stim();
    gap_pct = 30;
    for (int n = 0; n < 150; n++) stim.push_back(rand_bundle());
    run_stim();
    gap_pct = 0;
    for (int n = 0; n < 40; n++) stim.push_back(rand_bundle());
    run_stim();

    // ---------------- 2 lanes, 2 ports ----------------
    select(2, 2, 2);
    gap_pct = 0;
    for (int n = 0; n < 60; n++) stim.push_back(rand_bundle());
    run_stim();
    gap_pct = 30;
    for (int n = 0; n < 60; n++) stim.push_back(rand_bundle());
    run_stim();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_back_multi.md
Name: write_back_multi

Overview:
- Multi-lane commit stage for the MIPS pipeline; successor to the single-lane write-back.
- Accepts one bundle of LANES results per handshake and drains register-file writes through WPORTS write ports over one or more cycles.
- Owns the architectural HI/LO registers and updates them atomically when a bundle retires.
- Sits between the memory stage and the register file; back-pressures memory via in_ready.

Parameters:
LANES, 2, commit lanes per bundle (1..4)
WPORTS, 1, register-file write ports (1..LANES)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  bundle valid
in_ready  out  1  stage can accept a bundle this cycle
in_wen  in  LANES  per-lane regfile write request
in_regw  in  LANES*AW  per-lane destination; lane i at [i*AW +: AW]
in_data  in  LANES*DW  per-lane write data
in_hi_w  in  LANES  per-lane HI write
in_lo_w  in  LANES  per-lane LO write
in_hi_data  in  LANES*DW  per-lane HI data
in_lo_data  in  LANES*DW  per-lane LO data
rf_we  out  WPORTS  write enable per port
rf_wa  out  WPORTS*AW  write address per port
rf_wd  out  WPORTS*DW  write data per port
hi_o  out  DW  architectural HI (registered)
lo_o  out  DW  architectural LO (registered)
retire  out  1  one-cycle pulse: bundle fully committed this cycle
busy  out  1  holding register occupied

Behaviour:
- Reset (async, resetn=0): state IDLE, pending mask 0, hi_o=lo_o=0, rf_we=0, retire=0, busy=0, in_ready=1.
- States: IDLE (buffer empty), DRAIN (buffer holds a bundle).
- Handshake: transfer on in_valid&in_ready at a rising edge. in_ready = IDLE | (DRAIN & last drain cycle); back-to-back bundles have no bubble.
- Capture: data into the holding register; pending[i] = in_wen[i] & (in_regw[i]!=0) & no lane j>i with a valid write to the same in_regw. This is a WAW collapse: the highest lane wins, and drain order is irrelevant.
- Drain: each cycle in DRAIN, the lowest-index pending lanes, up to WPORTS of them, are driven on ports 0..WPORTS-1 in ascending lane order. Their pending bits clear at the edge. Unused ports have rf_we=0 and rf_wa/rf_wd=0.
- Outputs rf_* are combinational from the holding register. The first write appears in the cycle after acceptance (latency 1).
- Last drain cycle: pending popcount <= WPORTS. This includes a bundle with zero writes, which still spends exactly one DRAIN cycle.
- Drain cycles = max(1, ceil(k/WPORTS)), where k = popcount(pending) at capture.
- Retire (last drain cycle): retire=1 that cycle.
  - HI takes the data of the highest lane with hi_w set; LO likewise. Lanes without a set bit leave the register unchanged.
  - hi_o/lo_o show new values from the next cycle.
- Next state after retire: DRAIN if a new bundle is accepted in the same cycle, else IDLE.
- in_valid while !in_ready: ignored; the producer holds the bundle stable.
- Lanes with regw=0 never write, even with wen=1; their HI/LO writes still apply.
- Reset asserted mid-drain: remaining writes are discarded, HI/LO clear to 0, no retire pulse.
- WPORTS=LANES: every bundle drains in exactly one cycle; in_ready stays 1 continuously.

Test Plan:
- Defaults; bundle L0 {wen,r3,0x11}, L1 {wen,r4,0x22} -> cycle+1: rf_wa=3, rf_wd=0x11; cycle+2: rf_wa=4, rf_wd=0x22, retire=1. in_ready=0 during cycle+1.
- Bundle L0 {r5,0xAA}, L1 {r5,0xBB} -> a single write r5=0xBB, retire in cycle+1, in_ready stays 1.
- L0 {wen,r0,0x55, hi_w hi=0x1}, L1 {no wen, lo_w lo=0x2} -> rf_we never asserts; retire at cycle+1; hi_o=0x1 and lo_o=0x2 from cycle+2.
- Both lanes hi_w with 0x7 and 0x9 -> hi_o=0x9, lo_o unchanged.
- Three back-to-back two-write bundles with in_valid held -> writes every cycle with no idle port cycle, and a retire every 2 cycles.
- resetn pulsed low in the first drain cycle of a two-write bundle -> second write never issued, hi_o=lo_o=0, in_ready=1 immediately.
- LANES=4, WPORTS=2, four distinct writes -> two per cycle over 2 cycles, ports in lane order 0,1 then 2,3.
